gemm_issue_ctrl: RTL
====================

Name: gemm_issue_ctrl

Overview:
- Issue-side reader of the single-row GEMM functional-unit status table (FUST-G).
- Holds a row written by dispatch until all matrix source operands are ready, then hands it to the GEMM unit over a valid/ready handshake.
- Drives the FUST-G `busy` input, tracks the one in-flight GEMM to completion, and releases the row.
- Sits between the FUST-G and the GEMM systolic-array front end.

Parameters:
- MREGS, 16, number of matrix registers.
- TAGW, $clog2(MREGS), width of a matrix-register tag.
- LAT_MAX, 64, watchdog limit in cycles for an in-flight GEMM.

Ports:
- CLK  in  1  clock.
- nRST  in  1  async active-low reset.
- fust_valid  in  1  FUST-G row occupied (row written by dispatch).
- fust_md  in  TAGW  destination matrix register.
- fust_ms1, fust_ms2, fust_ms3  in  TAGW each  source matrices A, B, C.
- fust_t1, fust_t2, fust_t3  in  1 each  source pending (1 = wait for producer).
- wb_valid  in  1  matrix writeback broadcast.
- wb_tag  in  TAGW  register written back.
- gemm_ready  in  1  GEMM unit accepts a new op.
- gemm_done  in  1  GEMM unit completion pulse.
- flush  in  1  squash the held row and any not-yet-accepted op.
- busy  out  1  to FUST-G `busy` input.
- gemm_valid  out  1  op offered to GEMM unit.
- gemm_md, gemm_ms1, gemm_ms2, gemm_ms3  out  TAGW each  latched operand tags.
- gemm_wb_valid  out  1  one-cycle completion broadcast.
- gemm_wb_tag  out  TAGW  destination tag of the completed op.
- timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset: async on nRST low. State=IDLE; busy, gemm_valid, gemm_wb_valid and timeout = 0; all tag outputs = 0; pending flags = 0.
- IDLE:
  - If fust_valid, capture md/ms1–3 and t1–3 into registers; go to WAIT.
  - Same-cycle wakeup: if wb_valid and wb_tag equals a source whose t=1, that pending bit is captured as 0.
- WAIT:
  - Each cycle, wb_valid with wb_tag == ms_k clears pending_k. A single broadcast may clear several bits.
  - When all pending bits are 0, go to ISSUE on the next edge.
  - busy=1 from entry to WAIT.
- ISSUE:
  - gemm_valid=1 with registered tags.
  - Outputs are held stable until gemm_ready is sampled high. The transfer completes when valid & ready; then go to EXEC.
  - gemm_valid must not drop before the transfer.
- EXEC:
  - gemm_valid=0; a cycle counter increments.
  - On gemm_done: pulse gemm_wb_valid=1 with gemm_wb_tag=md for exactly one cycle; clear busy; return to IDLE.
  - If the counter reaches LAT_MAX-1 without gemm_done, set timeout (sticky until reset) and remain in EXEC.
- Latency: row with no pending sources → gemm_valid 2 cycles after fust_valid is sampled (capture edge, ISSUE edge).
- busy is 1 in WAIT, ISSUE and EXEC; 0 in IDLE. The row is released on the cycle gemm_wb_valid pulses.
- flush:
  - In WAIT or ISSUE (before the transfer): return to IDLE next edge; clear busy and gemm_valid; no wb pulse.
  - In EXEC: ignored; completion still broadcasts.
  - flush has priority over a same-cycle ready.
- gemm_done outside EXEC is ignored.
- fust_valid in a non-IDLE state is ignored; dispatch must not write while busy=1.
- The counter saturates; it does not wrap.

Optional Feature:
- GEMM_ISSUE_PERF_EN.
- When defined, adds outputs perf_stall_ops (32b, cycles in WAIT), perf_stall_fu (32b, cycles in ISSUE with gemm_ready=0) and perf_issued (32b, accepted ops).
- All three reset to 0 and saturate at all-ones.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared datapath package:
  - issue state enum gemm_issue_state_t {IDLE, WAIT, ISSUE, EXEC};
  - matrix tag typedef mreg_t;
  - GEMM request struct gemm_req_t {md, ms1, ms2, ms3};
  - LAT_MAX constant.
- One sub-module: gemm_wakeup. It is purely combinational: per-source tag compare against the wb bus, producing the pending-bit clear vector.

Test Plan:
- All t=0, ms=1,2,3, md=4, gemm_ready=1 → gemm_valid at cycle 2 with tags 4/1/2/3; gemm_done at cycle 10 → gemm_wb_valid=1 with tag 4 for one cycle; busy falls to 0.
- t1=1, ms1=5; wb_tag=5 at cycle 6 → gemm_valid first asserted at cycle 7. wb_tag=6 must not wake it.
- ms1=ms2=7, both pending; a single wb_tag=7 clears both → issues.
- gemm_ready held 0 for 5 cycles → gemm_valid and tags stable throughout; perf_stall_fu=5 with GEMM_ISSUE_PERF_EN.
- flush in WAIT → IDLE, busy=0, no wb pulse. flush in EXEC → wb pulse still occurs on gemm_done.
- nRST low during EXEC → all outputs 0 immediately. No gemm_done for LAT_MAX cycles → timeout=1 and stays 1.

Source files
------------

// File: rtl/gemm_issue_ctrl_pkg.sv
// Shared types and constants for the FUST-G issue controller.
package gemm_issue_ctrl_pkg;

   localparam int MREGS   = 16;
   localparam int TAGW    = $clog2(MREGS);
   localparam int LAT_MAX = 64;

   typedef logic [TAGW-1:0] mreg_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ISSUE,
      EXEC
   } gemm_issue_state_t;

   typedef struct packed {
      mreg_t md;
      mreg_t ms1;
      mreg_t ms2;
      mreg_t ms3;
   } gemm_req_t;

endpackage

// File: rtl/gemm_issue_ctrl_wakeup.sv
// Combinational operand wakeup: compares the writeback tag against the
// three source tags and reports which pending bits it clears.
module gemm_wakeup #(
   parameter int TAGW = gemm_issue_ctrl_pkg::TAGW
) (
   input  logic            wb_valid,
   input  logic [TAGW-1:0] wb_tag,
   input  logic [TAGW-1:0] ms1,
   input  logic [TAGW-1:0] ms2,
   input  logic [TAGW-1:0] ms3,
   output logic [2:0]      clr
);

   // One broadcast may match several sources that name the same register.
   assign clr[0] = wb_valid && (wb_tag == ms1);
   assign clr[1] = wb_valid && (wb_tag == ms2);
   assign clr[2] = wb_valid && (wb_tag == ms3);

endmodule

// File: rtl/gemm_issue_ctrl.sv
// Issue controller for the single-row GEMM status table (FUST-G).
// Holds the dispatched row until its sources are ready, hands it to the
// GEMM unit over valid/ready, tracks it to completion and releases the row.
// Optional performance counters are built when GEMM_ISSUE_PERF_EN is defined.
module gemm_issue_ctrl #(
   parameter int MREGS   = gemm_issue_ctrl_pkg::MREGS,
   parameter int TAGW    = $clog2(MREGS),
   parameter int LAT_MAX = gemm_issue_ctrl_pkg::LAT_MAX
) (
   input  logic            CLK,
   input  logic            nRST,
   input  logic            fust_valid,
   input  logic [TAGW-1:0] fust_md,
   input  logic [TAGW-1:0] fust_ms1,
   input  logic [TAGW-1:0] fust_ms2,
   input  logic [TAGW-1:0] fust_ms3,
   input  logic            fust_t1,
   input  logic            fust_t2,
   input  logic            fust_t3,
   input  logic            wb_valid,
   input  logic [TAGW-1:0] wb_tag,
   input  logic            gemm_ready,
   input  logic            gemm_done,
   input  logic            flush,
   output logic            busy,
   output logic            gemm_valid,
   output logic [TAGW-1:0] gemm_md,
   output logic [TAGW-1:0] gemm_ms1,
   output logic [TAGW-1:0] gemm_ms2,
   output logic [TAGW-1:0] gemm_ms3,
   output logic            gemm_wb_valid,
   output logic [TAGW-1:0] gemm_wb_tag,
   output logic            timeout
`ifdef GEMM_ISSUE_PERF_EN
   ,
   output logic [31:0]     perf_stall_ops,
   output logic [31:0]     perf_stall_fu,
   output logic [31:0]     perf_issued
`endif
);

   import gemm_issue_ctrl_pkg::*;

   localparam int             CNT_W   = $clog2(LAT_MAX);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LAT_MAX - 1);

   gemm_issue_state_t state, state_nxt;
   gemm_req_t         req;
   logic [2:0]        pend;
   logic [2:0]        wk_clr;
   logic [CNT_W-1:0]  cnt;
   logic [TAGW-1:0]   cmp_ms1, cmp_ms2, cmp_ms3;
   logic              xfer;

   // In IDLE the incoming row is compared so a same-cycle broadcast is not lost.
   assign cmp_ms1 = (state == IDLE) ? fust_ms1 : TAGW'(req.ms1);
   assign cmp_ms2 = (state == IDLE) ? fust_ms2 : TAGW'(req.ms2);
   assign cmp_ms3 = (state == IDLE) ? fust_ms3 : TAGW'(req.ms3);

   gemm_wakeup #(.TAGW(TAGW)) u_wakeup (
      .wb_valid (wb_valid),
      .wb_tag   (wb_tag),
      .ms1      (cmp_ms1),
      .ms2      (cmp_ms2),
      .ms3      (cmp_ms3),
      .clr      (wk_clr)
   );

   // A flush in ISSUE wins over a same-cycle ready.
   assign xfer = (state == ISSUE) && gemm_ready && !flush;

   assign busy       = (state != IDLE);
   assign gemm_valid = (state == ISSUE);
   assign gemm_md    = TAGW'(req.md);
   assign gemm_ms1   = TAGW'(req.ms1);
   assign gemm_ms2   = TAGW'(req.ms2);
   assign gemm_ms3   = TAGW'(req.ms3);

   // Next-state logic for the issue FSM.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_nxt = state;
      case (state)
         IDLE:    if (fust_valid) state_nxt = WAIT;
         WAIT:    if (flush) state_nxt = IDLE;
                  else if ((pend & ~wk_clr) == 3'b000) state_nxt = ISSUE;
         ISSUE:   if (flush) state_nxt = IDLE;
                  else if (gemm_ready) state_nxt = EXEC;
         EXEC:    if (gemm_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge nRST) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!nRST) state <= IDLE;
      else       state <= state_nxt;
   end

   // Row capture and operand wakeup tracking.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         req  <= '0;
         pend <= '0;
      end else begin
         case (state)
            IDLE: if (fust_valid) begin
               req  <= '{md:  mreg_t'(fust_md),  ms1: mreg_t'(fust_ms1),
                         ms2: mreg_t'(fust_ms2), ms3: mreg_t'(fust_ms3)};
               pend <= {fust_t3, fust_t2, fust_t1} & ~wk_clr;
            end
            WAIT: pend <= flush ? 3'b000 : (pend & ~wk_clr);
            default: ;
         endcase
      end
   end

   // Execution watchdog: saturating cycle counter and sticky timeout.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt     <= '0;
         timeout <= 1'b0;
      end else begin
         if (xfer)
            cnt <= '0;
         else if (state == EXEC && cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
         if (state == EXEC && !gemm_done && cnt == CNT_MAX)
            timeout <= 1'b1;
      end
   end

   // One-cycle completion broadcast, aligned with the row release.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         gemm_wb_valid <= 1'b0;
         gemm_wb_tag   <= '0;
      end else begin
         gemm_wb_valid <= (state == EXEC) && gemm_done;
         if (state == EXEC && gemm_done)
            gemm_wb_tag <= TAGW'(req.md);
      end
   end

`ifdef GEMM_ISSUE_PERF_EN
   // Saturating performance counters.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         perf_stall_ops <= '0;
         perf_stall_fu  <= '0;
         perf_issued    <= '0;
      end else begin
         if (state == WAIT && perf_stall_ops != '1)
            perf_stall_ops <= perf_stall_ops + 1'b1;
         if (state == ISSUE && !gemm_ready && perf_stall_fu != '1)
            perf_stall_fu <= perf_stall_fu + 1'b1;
         if (xfer && perf_issued != '1)
            perf_issued <= perf_issued + 1'b1;
      end
   end
`endif

endmodule
